fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  F-stage program-counter generator and F->D pipeline register for PC-side state. Drives the
//  word address into prog_mem and holds PCD/PCPlus4D/PCPlus8D in lockstep with prog_mem's
//  registered RD. Takes the execute-stage redirect and enforces a fatal fetch-fault state.
// PARAMETERS
//  SIZE_LOG2  13        prog_mem word-address width; legal byte PC range is [0, 2**(SIZE_LOG2+2))
//  RESET_PC   32'h0     PCF value after reset; must be word aligned
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous reset, active low; top drives prog_mem rst = ~rst_n
//  StallF     in   1          hold PCF
//  StallD     in   1          hold D registers; same signal prog_mem receives
//  FlushD     in   1          bubble D registers; same signal prog_mem receives
//  PCSrcE     in   1          redirect request from execute
//  PCTargetE  in   32         redirect byte address
//  A          out  SIZE_LOG2  prog_mem address = PCF[SIZE_LOG2+1:2], combinational from PCF
//  PCF        out  32         current fetch PC
//  PCPlus4F   out  32         PCF + 4, combinational
//  PCD        out  32         PC of the instruction on prog_mem RD
//  PCPlus4D   out  32         PCD + 4 (RISC-V link value)
//  PCPlus8D   out  32         PCD + 8 (ARM architectural PC read)
//  ValidD     out  1          RD holds a real instruction; 0 means bubble
//  FaultF     out  1          sticky fetch fault
//  FetchCnt   out  32         count of valid instructions delivered to D
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): PCF=RESET_PC; PCD=PCPlus4D=PCPlus8D=0; ValidD=0; FaultF=0;
//    FetchCnt=0; state=RUN. Reset overrides every other input.
//  - Latency: prog_mem latches mem[A] on the same edge that PCD<=PCF. RD and PCD/ValidD are
//    always from the same fetch.
//  - Next PC in RUN, priority high->low:
//      PCSrcE=1 and target legal   -> PCTargetE (overrides StallF)
//      PCSrcE=1 and target illegal -> PCF held; state->FAULT
//      StallF=1                    -> hold
//      otherwise                   -> PCPlus4F
//  - Illegal target: PCTargetE[1:0]!=0, or any bit in PCTargetE[31:SIZE_LOG2+2] set.
//  - Sequential wrap: PCPlus4F is 32-bit modulo. Crossing 2**(SIZE_LOG2+2) without a redirect
//    causes no fault, and A wraps to 0.
//  - D registers, priority high->low (same order as prog_mem):
//      FlushD=1 -> PCD/PCPlus4D/PCPlus8D=0, ValidD=0
//      StallD=1 -> hold
//      else     -> PCD<=PCF, PCPlus4D<=PCPlus4F, PCPlus8D<=PCF+8,
//                  ValidD<=(state==RUN && !StallF)
//    ValidD=0 on a StallF&!StallD edge, because prog_mem re-reads the same word as a
//    duplicate, not as a new instruction.
//  - FetchCnt increments by 1 on each edge where ValidD is loaded as 1; wraps at 2**32.
//  - FSM RUN/FAULT: RUN->FAULT on an illegal redirect; FAULT exits only on reset.
//    In FAULT: PCF frozen, FaultF=1, ValidD loads 0, PCSrcE/StallF ignored.
//    FlushD/StallD still act on the D registers.
//  - Simultaneous FlushD & StallD: flush wins. Simultaneous PCSrcE & StallF: redirect wins;
//    the hazard unit must assert FlushD with it.
// STRUCTURE
//  - Package fetch_pkg: typedef enum logic {FS_RUN, FS_FAULT} fetch_state_t; localparams
//    PC_W=32, INSTR_BYTES=4.
//  - One sub-module fetch_target_chk (combinational, parameter SIZE_LOG2): input PCTargetE,
//    output illegal.
//  - All state sits in one always_ff with synchronous rst_n. Next-PC mux is in always_comb.
// TESTING
//  - Reset release, RESET_PC=0, no stalls -> edge1: PCD=0, ValidD=1; edge2: PCD=4,
//    PCPlus8D=12; FetchCnt=2.
//  - StallF=StallD=1 for 3 cycles at PCF=0x10 -> PCF, PCD, RD and FetchCnt held;
//    on release PCF=0x14.
//  - PCSrcE=1, PCTargetE=0x40, FlushD=1 with StallF=1 -> next PCF=0x40, ValidD=0, PCD=0;
//    following edge PCD=0x40, ValidD=1.
//  - PCSrcE=1, PCTargetE=0x42 -> FaultF=1, PCF frozen, ValidD=0 thereafter.
//    PCTargetE=1<<(SIZE_LOG2+2) behaves the same.
//  - Sequential run to PCF=2**(SIZE_LOG2+2)-4 -> next A=0, FaultF stays 0.
//  - rst_n=0 for one cycle while in FAULT with PCD!=0 -> all outputs at reset values,
//    state RUN, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit.
//   PC_W         : width of byte program counters
//   INSTR_BYTES  : bytes per instruction word (sequential PC step)
//   fetch_state_t: RUN = normal fetching, FAULT = frozen after an illegal redirect
package fetch_pkg;
  localparam int PC_W        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {FS_RUN, FS_FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bundle between the fetch PC unit and the hazard/execute/prog_mem side.
// master: hazard unit + execute stage (drives stalls, flush, redirect; reads PCs)
// slave : fetch_pc_unit (drives prog_mem address, F/D PCs, valid, fault, count)
interface fetch_pc_unit_if import fetch_pkg::*; #(parameter int SIZE_LOG2 = 13) ();
  logic                 StallF;
  logic                 StallD;
  logic                 FlushD;
  logic                 PCSrcE;
  logic [PC_W-1:0]      PCTargetE;
  logic [SIZE_LOG2-1:0] A;
  logic [PC_W-1:0]      PCF;
  logic [PC_W-1:0]      PCPlus4F;
  logic [PC_W-1:0]      PCD;
  logic [PC_W-1:0]      PCPlus4D;
  logic [PC_W-1:0]      PCPlus8D;
  logic                 ValidD;
  logic                 FaultF;
  logic [31:0]          FetchCnt;

  modport master (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE,
    input  A, PCF, PCPlus4F, PCD, PCPlus4D, PCPlus8D, ValidD, FaultF, FetchCnt
  );

  modport slave (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE,
    output A, PCF, PCPlus4F, PCD, PCPlus4D, PCPlus8D, ValidD, FaultF, FetchCnt
  );
endinterface

// File: rtl/fetch_pc_unit_target_chk.sv
// Redirect target legality check (combinational).
//   target  : redirect byte address from execute
//   illegal : 1 when the target is misaligned or outside the program memory
module fetch_target_chk import fetch_pkg::*; #(
  parameter int SIZE_LOG2 = 13
) (
  input  logic [PC_W-1:0] target,
  output logic            illegal
);
  // Shifting the whole word keeps every bit of the target in the expression.
  assign illegal = (target[1:0] != 2'b00) || ((target >> (SIZE_LOG2 + 2)) != '0);
endmodule

// File: rtl/fetch_pc_unit.sv
// F-stage PC generator plus F->D register for the PC-side state. The D registers
// advance on the same edge prog_mem latches mem[A], so PCD/ValidD always describe RD.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of fetch_pc_unit_if (stalls, flush, redirect in;
//                A, PCF, PCPlus4F, PCD, PCPlus4D, PCPlus8D, ValidD, FaultF, FetchCnt out)
module fetch_pc_unit import fetch_pkg::*; #(
  parameter int              SIZE_LOG2 = 13,
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_pc_unit_if.slave    bus
);
  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_f, pc_next, pc_plus4_f;
  logic [PC_W-1:0] pc_d, pc_plus4_d, pc_plus8_d;
  logic            valid_d;
  logic [31:0]     fetch_cnt;
  logic            target_illegal;
  logic            fault_go;
  logic            valid_load;

  fetch_target_chk #(.SIZE_LOG2(SIZE_LOG2)) u_target_chk (
    .target  (bus.PCTargetE),
    .illegal (target_illegal)
  );

  assign pc_plus4_f = pc_f + INSTR_BYTES;

  // A stalled F re-reads the same word, so that fetch is a duplicate, not a new instruction.
  assign valid_load = (state_q == FS_RUN) && !bus.StallF;

  always_comb begin
    pc_next  = pc_f;
    fault_go = 1'b0;
    if (state_q == FS_RUN) begin
      if (bus.PCSrcE) begin
        if (target_illegal) fault_go = 1'b1;
        else                pc_next  = bus.PCTargetE;
      end else if (!bus.StallF) begin
        pc_next = pc_plus4_f;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FS_RUN;
      pc_f       <= RESET_PC;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      pc_plus8_d <= '0;
      valid_d    <= 1'b0;
      fetch_cnt  <= '0;
    end else begin
      if (fault_go) state_q <= FS_FAULT;
      pc_f <= pc_next;
      if (bus.FlushD) begin
        pc_d       <= '0;
        pc_plus4_d <= '0;
        pc_plus8_d <= '0;
        valid_d    <= 1'b0;
      end else if (!bus.StallD) begin
        pc_d       <= pc_f;
        pc_plus4_d <= pc_plus4_f;
        pc_plus8_d <= pc_f + 2 * INSTR_BYTES;
        valid_d    <= valid_load;
        if (valid_load) fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  assign bus.A        = pc_f[SIZE_LOG2+1:2];
  assign bus.PCF      = pc_f;
  assign bus.PCPlus4F = pc_plus4_f;
  assign bus.PCD      = pc_d;
  assign bus.PCPlus4D = pc_plus4_d;
  assign bus.PCPlus8D = pc_plus8_d;
  assign bus.ValidD   = valid_d;
  assign bus.FaultF   = (state_q == FS_FAULT);
  assign bus.FetchCnt = fetch_cnt;
endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  localparam int SL2 = 13;

  typedef struct {
    int          id;
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic [31:0] p4d;
    logic [31:0] p8d;
    logic        vd;
    logic        flt;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   vec_id = 0;
  exp_t q[$];

  fetch_pc_unit_if #(.SIZE_LOG2(SL2)) bus ();

  fetch_pc_unit #(.SIZE_LOG2(SL2), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL vec%0d %s: got %h want %h", id, name, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge.
  // bub=1 means the D registers are expected to hold the flushed/reset zero value.
  task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                      input logic src, input logic [31:0] tgt,
                      input logic [31:0] e_pcf, input logic [31:0] e_pcd, input logic bub,
                      input logic e_vd, input logic e_flt, input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst_n         = rst;
    bus.StallF    = sf;
    bus.StallD    = sd;
    bus.FlushD    = fd;
    bus.PCSrcE    = src;
    bus.PCTargetE = tgt;
    e.id  = vec_id;
    e.pcf = e_pcf;
    e.pcd = e_pcd;
    e.p4d = bub ? 32'h0 : e_pcd + 32'd4;
    e.p8d = bub ? 32'h0 : e_pcd + 32'd8;
    e.vd  = e_vd;
    e.flt = e_flt;
    e.cnt = e_cnt;
    q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare every output once per edge against the queued expectation.
  initial begin
    exp_t e;
    logic [31:0] e_a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        e_a = 32'(e.pcf[SL2+1:2]);
        chk("PCF",      e.id, bus.PCF,                e.pcf);
        chk("A",        e.id, 32'(bus.A),             e_a);
        chk("PCPlus4F", e.id, bus.PCPlus4F,           e.pcf + 32'd4);
        chk("PCD",      e.id, bus.PCD,                e.pcd);
        chk("PCPlus4D", e.id, bus.PCPlus4D,           e.p4d);
        chk("PCPlus8D", e.id, bus.PCPlus8D,           e.p8d);
        chk("ValidD",   e.id, {31'b0, bus.ValidD},    {31'b0, e.vd});
        chk("FaultF",   e.id, {31'b0, bus.FaultF},    {31'b0, e.flt});
        chk("FetchCnt", e.id, bus.FetchCnt,           e.cnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.StallF = 0; bus.StallD = 0; bus.FlushD = 0; bus.PCSrcE = 0; bus.PCTargetE = '0;
    //   rst sf sd fd src target        PCF           PCD           bub vd flt cnt
    step(0, 0, 0, 0, 0, 32'h0,    32'h0,    32'h0,    1, 0, 0, 0);   // 0 reset
    step(1, 0, 0, 0, 0, 32'h0,    32'h4,    32'h0,    0, 1, 0, 1);   // 1 first fetch
    step(1, 0, 0, 0, 0, 32'h0,    32'h8,    32'h4,    0, 1, 0, 2);   // 2 PCPlus8D=12
    step(1, 0, 0, 0, 0, 32'h0,    32'hC,    32'h8,    0, 1, 0, 3);
    step(1, 0, 0, 0, 0, 32'h0,    32'h10,   32'hC,    0, 1, 0, 4);
    for (int i = 0; i < 3; i++)                                     // 5-7 full stall
      step(1, 1, 1, 0, 0, 32'h0,  32'h10,   32'hC,    0, 1, 0, 4);
    step(1, 0, 0, 0, 0, 32'h0,    32'h14,   32'h10,   0, 1, 0, 5);   // 8 release
    step(1, 1, 0, 0, 0, 32'h0,    32'h14,   32'h14,   0, 0, 0, 5);   // 9 duplicate read
    step(1, 0, 0, 0, 0, 32'h0,    32'h18,   32'h14,   0, 1, 0, 6);
    step(1, 1, 0, 1, 1, 32'h40,   32'h40,   32'h0,    1, 0, 0, 6);   // 11 redirect beats stall
    step(1, 0, 0, 0, 0, 32'h0,    32'h44,   32'h40,   0, 1, 0, 7);
    step(1, 0, 0, 1, 1, 32'h7FF8, 32'h7FF8, 32'h0,    1, 0, 0, 7);   // 13 redirect near top
    step(1, 0, 0, 0, 0, 32'h0,    32'h7FFC, 32'h7FF8, 0, 1, 0, 8);
    step(1, 0, 0, 0, 0, 32'h0,    32'h8000, 32'h7FFC, 0, 1, 0, 9);   // 15 A wraps to 0
    step(1, 0, 0, 0, 0, 32'h0,    32'h8004, 32'h8000, 0, 1, 0, 10);
    step(1, 0, 1, 1, 0, 32'h0,    32'h8008, 32'h0,    1, 0, 0, 10);  // 17 flush beats stall
    step(1, 0, 0, 0, 0, 32'h0,    32'h800C, 32'h8008, 0, 1, 0, 11);
    step(1, 0, 0, 0, 1, 32'h42,   32'h800C, 32'h800C, 0, 1, 1, 12);  // 19 misaligned target
    step(1, 0, 0, 0, 0, 32'h0,    32'h800C, 32'h800C, 0, 0, 1, 12);
    step(1, 0, 0, 0, 1, 32'h80,   32'h800C, 32'h800C, 0, 0, 1, 12);  // 21 redirect ignored
    step(1, 1, 0, 0, 0, 32'h0,    32'h800C, 32'h800C, 0, 0, 1, 12);
    step(1, 0, 0, 1, 0, 32'h0,    32'h800C, 32'h0,    1, 0, 1, 12);  // 23 flush in FAULT
    step(1, 0, 0, 0, 0, 32'h0,    32'h800C, 32'h800C, 0, 0, 1, 12);
    step(0, 1, 1, 1, 1, 32'h42,   32'h0,    32'h0,    1, 0, 0, 0);   // 25 reset out of FAULT
    step(1, 0, 0, 0, 0, 32'h0,    32'h4,    32'h0,    0, 1, 0, 1);
    step(1, 0, 0, 0, 1, 32'h8000, 32'h4,    32'h4,    0, 1, 1, 2);   // 27 out-of-range target
    step(1, 0, 0, 0, 0, 32'h0,    32'h4,    32'h4,    0, 0, 1, 2);
    step(1, 0, 0, 0, 0, 32'h0,    32'h4,    32'h4,    0, 0, 1, 2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
